regfile_wb_scheduler: RTL
=========================

Name: regfile_wb_scheduler

Overview:
- Scoreboard and write-port scheduler in front of the 32x32 register file (one write port, register 0 hard-wired zero).
- Tracks destination registers with writes in flight from issued instructions, and stalls issue on RAW/WAW hazards against them.
- Arbitrates two writeback requesters (ALU, memory/long-latency) onto the single write port.
- Drives the register file's regwrite/write_register/write_data inputs.

Parameters:
- DATA_W, 32, data width.
- ADDR_W, 5, register index width (2**ADDR_W registers).
- MAX_PENDING, 8, max outstanding writes tracked.
- CNT_W, 4, width of pending counter; must hold MAX_PENDING.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- issue_valid  in  1  decode presents an instruction.
- issue_ready  out  1  instruction may issue this cycle.
- issue_rs  in  ADDR_W  source register 1.
- issue_rt  in  ADDR_W  source register 2.
- issue_rd  in  ADDR_W  destination register.
- issue_wr  in  1  instruction writes issue_rd.
- alu_wb_valid  in  1  ALU writeback request.
- alu_wb_ready  out  1  ALU request granted.
- alu_wb_reg  in  ADDR_W  ALU target register.
- alu_wb_data  in  DATA_W  ALU result.
- mem_wb_valid  in  1  memory writeback request.
- mem_wb_ready  out  1  memory request granted.
- mem_wb_reg  in  ADDR_W  memory target register.
- mem_wb_data  in  DATA_W  memory result.
- regwrite  out  1  register file write enable.
- write_register  out  ADDR_W  register file write index.
- write_data  out  DATA_W  register file write data.
- busy_vec  out  2**ADDR_W  scoreboard bits.
- pending_cnt  out  CNT_W  outstanding writes.
- wb_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (sync, rst=1 at edge): busy_vec=0, pending_cnt=0, regwrite=0, write_register=0, write_data=0, wb_err=0, round-robin pointer = ALU-first. Any in-flight tracking is discarded. Reset overrides all same-cycle issue/writeback events.
- busy_vec[0] is constant 0; never set.
- issue_ready is combinational from registered state only, with no same-cycle bypass of a clearing writeback. It is 0 if any of these holds:
  - busy[rs]=1
  - busy[rt]=1
  - issue_wr=1 and busy[rd]=1 (WAW)
  - issue_wr=1, rd!=0 and pending_cnt==MAX_PENDING
- Issue fire = issue_valid & issue_ready. If issue_wr=1 and rd!=0, busy[rd] is set and pending_cnt increments at the next edge. A fire with rd=0 or issue_wr=0 changes no state.
- Writeback arbitration is combinational:
  - Single valid requester: granted.
  - Both valid: the requester not granted last wins. The pointer updates only on a contended grant.
  - alu_wb_ready/mem_wb_ready = grant; at most one is high.
- Grant effect, 1-cycle latency: next edge regwrite=1, write_register=reg, write_data=data, unless reg=0. For reg=0: regwrite=0, request consumed, no scoreboard change.
- On a grant with reg!=0: busy[reg] cleared and pending_cnt decremented at the next edge.
- No grant: regwrite=0 next cycle. write_register/write_data hold their values.
- Grant to reg!=0 with busy[reg]=0: write still performed, counter unchanged, wb_err set (sticky until reset).
- Issue increment and writeback decrement in the same cycle: pending_cnt unchanged; set and clear apply to different registers. A same-register set+clear cannot occur legally, because issue is blocked while rd is busy.
- A busy register cleared at edge N is issuable from cycle N (first cycle after the clear).

Decomposition:
- Package regfile_ctrl_pkg: DATA_W, ADDR_W, NUM_REGS, and the requester enum REQ_ALU=0/REQ_MEM=1 for the arbiter pointer.
- Sub-module wb_rr_arbiter: 2-input round-robin (valid in, grant out, pointer register, same clk/rst).
- The scoreboard, counter and write-port register stay in the top module.

Test Plan:
- Reset then issue rd=5 (wr=1) -> busy_vec[5]=1, pending_cnt=1. Next issue with rs=5 -> issue_ready=0. ALU wb reg 5 data 0xDEADBEEF -> next cycle regwrite=1, write_register=5, write_data=0xDEADBEEF, busy clear, rs=5 issue ready.
- Issue rd=3 and rd=4. ALU and mem both valid (regs 3, 4) same cycle -> ALU granted first, mem next cycle. Two repeated contended pairs alternate grants.
- Issue 8 writes to regs 1..8 -> pending_cnt=8. Issue rd=9 wr=1 -> issue_ready=0. Issue wr=0 rs=10 -> issue_ready=1. One wb -> count 7, rd=9 ready.
- Issue rd=0 -> no busy change. Wb reg 0 -> ready=1, regwrite=0 next cycle, wb_err=0.
- Wb to reg 12 never issued -> regwrite=1, wb_err=1 stays set until rst.
- Issue rd=6 while ALU wb reg 2 granted same cycle -> pending_cnt unchanged. Assert rst with busy regs -> busy_vec=0, count 0, regwrite=0 next cycle.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared widths and the writeback requester encoding for the register-file write scheduler.
// Combinational definitions only: no latency, no backpressure.
package regfile_ctrl_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter between ALU and memory writeback requests.
// Grant is combinational, same cycle; priority flips only when both contend and one is granted.
module wb_rr_arbiter
    import regfile_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic alu_vld,
    input  logic mem_vld,
    output logic alu_gnt,
    output logic mem_gnt
);

    // prio_q names the requester that wins the next contended cycle.
    req_e prio_q;
    req_e prio_d;

    always_comb begin
        alu_gnt = alu_vld & (~mem_vld | (prio_q == REQ_ALU));
        mem_gnt = mem_vld & (~alu_vld | (prio_q == REQ_MEM));
        prio_d  = prio_q;
        if (alu_vld && mem_vld) begin
            prio_d = (prio_q == REQ_ALU) ? REQ_MEM : REQ_ALU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= REQ_ALU;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write scheduler: RAW/WAW scoreboard, pending-write counter, single write port.
// Write lands 1 cycle after grant; issue stalls on hazards or a full pending counter.
module regfile_wb_scheduler
    import regfile_ctrl_pkg::*;
#(
    parameter int DATA_W      = regfile_ctrl_pkg::DATA_W,
    parameter int ADDR_W      = regfile_ctrl_pkg::ADDR_W,
    parameter int MAX_PENDING = 8,
    parameter int CNT_W       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [ADDR_W-1:0]      issue_rs,
    input  logic [ADDR_W-1:0]      issue_rt,
    input  logic [ADDR_W-1:0]      issue_rd,
    input  logic                   issue_wr,
    input  logic                   alu_wb_valid,
    output logic                   alu_wb_ready,
    input  logic [ADDR_W-1:0]      alu_wb_reg,
    input  logic [DATA_W-1:0]      alu_wb_data,
    input  logic                   mem_wb_valid,
    output logic                   mem_wb_ready,
    input  logic [ADDR_W-1:0]      mem_wb_reg,
    input  logic [DATA_W-1:0]      mem_wb_data,
    output logic                   regwrite,
    output logic [ADDR_W-1:0]      write_register,
    output logic [DATA_W-1:0]      write_data,
    output logic [2**ADDR_W-1:0]   busy_vec,
    output logic [CNT_W-1:0]       pending_cnt,
    output logic                   wb_err
);

    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0]   busy_q,     busy_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] wreg_q,     wreg_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic              err_q,      err_d;

    logic              gnt_vld;
    logic [ADDR_W-1:0] gnt_reg;
    logic [DATA_W-1:0] gnt_dat;
    logic              issue_set;
    logic              wb_clr;

    wb_rr_arbiter u_arb (
        .clk     (clk),
        .rst     (rst),
        .alu_vld (alu_wb_valid),
        .mem_vld (mem_wb_valid),
        .alu_gnt (alu_wb_ready),
        .mem_gnt (mem_wb_ready)
    );

    // Ready looks only at registered state; a clear landing this cycle is not bypassed.
    always_comb begin
        issue_ready = 1'b1;
        if (busy_q[issue_rs] || busy_q[issue_rt]) begin
            issue_ready = 1'b0;
        end
        if (issue_wr && busy_q[issue_rd]) begin
            issue_ready = 1'b0;
        end
        if (issue_wr && (issue_rd != '0) && (cnt_q == CNT_W'(MAX_PENDING))) begin
            issue_ready = 1'b0;
        end
    end

    always_comb begin
        gnt_vld   = alu_wb_ready | mem_wb_ready;
        gnt_reg   = alu_wb_ready ? alu_wb_reg  : mem_wb_reg;
        gnt_dat   = alu_wb_ready ? alu_wb_data : mem_wb_data;
        issue_set = issue_valid & issue_ready & issue_wr & (issue_rd != '0);
        wb_clr    = gnt_vld & (gnt_reg != '0) & busy_q[gnt_reg];

        busy_d = busy_q;
        if (wb_clr) begin
            busy_d[gnt_reg] = 1'b0;
        end
        if (issue_set) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        cnt_d = cnt_q;
        if (issue_set && !wb_clr) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (wb_clr && !issue_set) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        // A granted write to r0 is consumed silently and leaves the port registers alone.
        regwrite_d = gnt_vld & (gnt_reg != '0);
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        if (regwrite_d) begin
            wreg_d  = gnt_reg;
            wdata_d = gnt_dat;
        end

        err_d = err_q | (gnt_vld & (gnt_reg != '0) & ~busy_q[gnt_reg]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            cnt_q      <= '0;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
        end
    end

    assign regwrite       = regwrite_q;
    assign write_register = wreg_q;
    assign write_data     = wdata_q;
    assign busy_vec       = busy_q;
    assign pending_cnt    = cnt_q;
    assign wb_err         = err_q;

endmodule
